// File: rtl/adder_arbiter_if.sv
// Bundles both requester ports, the shared-adder port and the response port of adder_arbiter.
interface adder_arbiter_if;
  logic       io_req0_valid;
  logic       io_req0_ready;
  logic [7:0] io_req0_a;
  logic [7:0] io_req0_b;
  logic       io_req0_cin;
  logic       io_req1_valid;
  logic       io_req1_ready;
  logic [7:0] io_req1_a;
  logic [7:0] io_req1_b;
  logic       io_req1_cin;
  logic [7:0] io_add_a;
  logic [7:0] io_add_b;
  logic       io_add_cin;
  logic [7:0] io_add_sum;
  logic       io_add_cout;
  logic       io_resp_valid;
  logic       io_resp_ready;
  logic       io_resp_id;
  logic [7:0] io_resp_sum;
  logic       io_resp_cout;
  logic       io_busy;

  modport slave (
    input  io_req0_valid, io_req0_a, io_req0_b, io_req0_cin,
    input  io_req1_valid, io_req1_a, io_req1_b, io_req1_cin,
    input  io_add_sum, io_add_cout, io_resp_ready,
    output io_req0_ready, io_req1_ready,
    output io_add_a, io_add_b, io_add_cin,
    output io_resp_valid, io_resp_id, io_resp_sum, io_resp_cout, io_busy
  );

  modport master (
    output io_req0_valid, io_req0_a, io_req0_b, io_req0_cin,
    output io_req1_valid, io_req1_a, io_req1_b, io_req1_cin,
    output io_add_sum, io_add_cout, io_resp_ready,
    input  io_req0_ready, io_req1_ready,
    input  io_add_a, io_add_b, io_add_cin,
    input  io_resp_valid, io_resp_id, io_resp_sum, io_resp_cout, io_busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared 8-bit adder with a fixed,
// parameterised adder latency and a backpressured single-entry response.
module adder_arbiter #(
  parameter int ADD_LATENCY = 1
) (
  input logic            clock,
  input logic            reset,
  adder_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(ADD_LATENCY);

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic       grant;
  logic       accept;
  logic       resp_id;
  logic [1:0] lat_cnt;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] resp_sum;
  logic       resp_cout;

  // A lone requester always wins; on a tie the requester not served last goes.
  always_comb begin
    grant = 1'b0;
    if (bus.io_req0_valid && bus.io_req1_valid) begin
      grant = ~last_grant;
    end else if (bus.io_req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is gated by reset so nothing looks acceptable while reset is held.
  assign bus.io_req0_ready = reset && (state == IDLE) && bus.io_req0_valid && !grant;
  assign bus.io_req1_ready = reset && (state == IDLE) && bus.io_req1_valid && grant;
  assign accept            = bus.io_req0_ready || bus.io_req1_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    if (lat_cnt == 2'd0) state_next = RESP;
      RESP:    if (bus.io_resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adder operands stay put from acceptance until the next acceptance, so the
  // shared adder sees stable inputs for the whole latency window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      resp_id    <= 1'b0;
      lat_cnt    <= 2'd0;
      add_a      <= 8'd0;
      add_b      <= 8'd0;
      add_cin    <= 1'b0;
      resp_sum   <= 8'd0;
      resp_cout  <= 1'b0;
    end else if (accept) begin
      add_a      <= grant ? bus.io_req1_a   : bus.io_req0_a;
      add_b      <= grant ? bus.io_req1_b   : bus.io_req0_b;
      add_cin    <= grant ? bus.io_req1_cin : bus.io_req0_cin;
      resp_id    <= grant;
      last_grant <= grant;
      lat_cnt    <= LAT_INIT;
    end else if (state == EXEC) begin
      if (lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end else begin
        resp_sum  <= bus.io_add_sum;
        resp_cout <= bus.io_add_cout;
      end
    end
  end

  assign bus.io_add_a      = add_a;
  assign bus.io_add_b      = add_b;
  assign bus.io_add_cin    = add_cin;
  assign bus.io_resp_valid = (state == RESP);
  assign bus.io_resp_id    = resp_id;
  assign bus.io_resp_sum   = resp_sum;
  assign bus.io_resp_cout  = resp_cout;
  assign bus.io_busy       = (state != IDLE);
endmodule
